// File: rtl/mips_cpu_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_bus_arbiter_if
//  Description : Avalon-style single-master memory bus between the CPU bus
//                arbiter (master modport) and the memory/slave side (slave
//                modport).
//                  address     32  bus address
//                  read         1  read strobe
//                  write        1  write strobe
//                  byteenable   4  lane enables
//                  writedata   32  store data
//                  readdata    32  read data, valid the cycle after acceptance
//                  waitrequest  1  slave stall
//  Revision    : 1.0  initial release
// ============================================================================
interface mips_cpu_bus_arbiter_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address,
        output read,
        output write,
        output byteenable,
        output writedata,
        input  readdata,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  byteenable,
        input  writedata,
        output readdata,
        output waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_bus_arbiter
//  Description : Shares the CPU's single memory master between the
//                instruction-fetch requester and the load/store requester.
//                Data requests win over fetches (the data access belongs to
//                the older instruction). Each transfer is sequenced through
//                waitrequest stalls and finished by a one-cycle done pulse.
//  Ports       : clk, reset          clock, synchronous active-high reset
//                if_req/if_addr      fetch request (level, held until done)
//                if_done/if_rdata    fetch complete pulse and instruction word
//                d_req/d_we/d_addr/  data request (level, held until done)
//                d_byteenable/d_wdata
//                d_done/d_rdata      data complete pulse and load word
//                bus (master)        Avalon-style memory bus
//                busy                FSM is not idle
//                bus_error           sticky timeout flag
//  Options     : MIPS_BUS_TIMEOUT_EN  enables the stall timeout; the
//                TIMEOUT_CYCLES parameter (default 255) then sets how many
//                waitrequest-high cycles a transfer may see before it is
//                aborted. Without the macro the bus waits indefinitely and
//                bus_error is constant 0.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_cpu_bus_arbiter (
    input  wire logic                   clk,
    input  wire logic                   reset,
    // fetch requester
    input  wire logic                   if_req,
    input  wire logic [31:0]            if_addr,
    output logic                        if_done,
    output logic [31:0]                 if_rdata,
    // load/store requester
    input  wire logic                   d_req,
    input  wire logic                   d_we,
    input  wire logic [31:0]            d_addr,
    input  wire logic [3:0]             d_byteenable,
    input  wire logic [31:0]            d_wdata,
    output logic                        d_done,
    output logic [31:0]                 d_rdata,
    // memory bus
    mips_cpu_bus_arbiter_if.master      bus,
    // status
    output logic                        busy,
    output logic                        bus_error
);

`ifdef MIPS_BUS_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 255;
    localparam int unsigned c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUS_F  = 3'd1,
        ST_BUS_D  = 3'd2,
        ST_RESP_F = 3'd3,
        ST_RESP_D = 3'd4
    } state_t;

    state_t      state_q,   state_d;
    logic [31:0] address_q, address_d;
    logic        read_q,    read_d;
    logic        write_q,   write_d;
    logic [3:0]  be_q,      be_d;
    logic [31:0] wdata_q,   wdata_d;
    logic        if_done_q, if_done_d;
    logic        d_done_q,  d_done_d;
    logic        w_finish;

`ifdef MIPS_BUS_TIMEOUT_EN
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               abort_q, abort_d;      // current response is a timeout abort
    logic               bus_error_q, bus_error_d;
    logic               w_timeout;
`endif

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        read_d    = read_q;
        write_d   = write_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        if_done_d = 1'b0;
        d_done_d  = 1'b0;
        w_finish  = 1'b0;
`ifdef MIPS_BUS_TIMEOUT_EN
        cnt_d       = cnt_q;
        abort_d     = abort_q;
        bus_error_d = bus_error_q;
        w_timeout   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef MIPS_BUS_TIMEOUT_EN
                cnt_d   = '0;
                abort_d = 1'b0;
`endif
                // Requester fields are captured only here; later changes on
                // the request inputs have no effect on the running transfer.
                if (d_req) begin
                    address_d = d_addr;
                    be_d      = d_byteenable;
                    wdata_d   = d_wdata;
                    read_d    = ~d_we;
                    write_d   = d_we;
                    state_d   = ST_BUS_D;
                end else if (if_req) begin
                    address_d = if_addr;
                    be_d      = 4'b1111;
                    wdata_d   = 32'd0;
                    read_d    = 1'b1;
                    write_d   = 1'b0;
                    state_d   = ST_BUS_F;
                end
            end

            ST_BUS_F, ST_BUS_D: begin
                w_finish = ~bus.waitrequest;
`ifdef MIPS_BUS_TIMEOUT_EN
                if (bus.waitrequest) begin
                    // Counter reaching TIMEOUT_CYCLES-1 here means this is the
                    // TIMEOUT_CYCLES-th stalled cycle.
                    if (cnt_q == c_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        w_timeout   = 1'b1;
                        w_finish    = 1'b1;
                        abort_d     = 1'b1;
                        bus_error_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                if (w_finish) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (state_q == ST_BUS_F) begin
                        state_d   = ST_RESP_F;
                        if_done_d = 1'b1;
                    end else begin
                        state_d   = ST_RESP_D;
                        d_done_d  = 1'b1;
                    end
                end
            end

            ST_RESP_F, ST_RESP_D: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            address_q <= 32'd0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            be_q      <= 4'd0;
            wdata_q   <= 32'd0;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
`ifdef MIPS_BUS_TIMEOUT_EN
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            bus_error_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            read_q    <= read_d;
            write_q   <= write_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            if_done_q <= if_done_d;
            d_done_q  <= d_done_d;
`ifdef MIPS_BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            bus_error_q <= bus_error_d;
`endif
        end
    end

    assign bus.address    = address_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.byteenable = be_q;
    assign bus.writedata  = wdata_q;

    assign if_done = if_done_q;
    assign d_done  = d_done_q;
    assign busy    = (state_q != ST_IDLE);

    // Read data is a straight pass-through from the bus in the response
    // cycle; an aborted transfer returns zero instead.
`ifdef MIPS_BUS_TIMEOUT_EN
    assign if_rdata  = abort_q ? 32'd0 : bus.readdata;
    assign d_rdata   = abort_q ? 32'd0 : bus.readdata;
    assign bus_error = bus_error_q;
`else
    assign if_rdata  = bus.readdata;
    assign d_rdata   = bus.readdata;
    assign bus_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_cpu_bus_arbiter
//  Description : Self-checking bench for mips_cpu_bus_arbiter. Directed
//                scenarios plus randomized transfers whose expected bus
//                activity and completion timing come from the transfer
//                latency rules (strobe cycles = stalls+1, done one cycle
//                after acceptance, idle the cycle after done).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_cpu_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_byteenable;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        busy;
    logic        bus_error;

    mips_cpu_bus_arbiter_if bus_if ();

    always #5 clk = ~clk;

`ifdef MIPS_BUS_TIMEOUT_EN
    mips_cpu_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
`else
    mips_cpu_bus_arbiter dut (
`endif
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_done      (if_done),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_byteenable (d_byteenable),
        .d_wdata      (d_wdata),
        .d_done       (d_done),
        .d_rdata      (d_rdata),
        .bus          (bus_if.master),
        .busy         (busy),
        .bus_error    (bus_error)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer through an otherwise idle arbiter. Called in an
    // IDLE cycle; returns in the IDLE cycle following the done pulse.
    task automatic xfer(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input int stalls, input logic [31:0] rd);
        logic       exp_read;
        logic       exp_write;
        logic [3:0] exp_be;
        exp_read  = is_d ? ~we : 1'b1;
        exp_write = is_d & we;
        exp_be    = is_d ? be : 4'b1111;

        check("idle_busy", busy, 1'b0);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_byteenable = be; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        bus_if.readdata = $urandom;
        tick();
        for (int k = 1; k <= stalls + 1; k++) begin
            check("strobe_read",  bus_if.read,       exp_read);
            check("strobe_write", bus_if.write,      exp_write);
            check("strobe_addr",  bus_if.address,    addr);
            check("strobe_be",    bus_if.byteenable, exp_be);
            if (exp_write) check("strobe_wdata", bus_if.writedata, wd);
            check("strobe_dones", {if_done, d_done}, 2'b00);
            check("strobe_busy",  busy, 1'b1);
            // Scramble the held fields; the latched bus values must not move.
            if (is_d) begin
                d_addr = $urandom; d_wdata = $urandom; d_byteenable = 4'($urandom); d_we = ~d_we;
            end else begin
                if_addr = $urandom;
            end
            bus_if.waitrequest = (k <= stalls);
            bus_if.readdata    = $urandom;
            tick();
        end
        bus_if.readdata    = rd;
        bus_if.waitrequest = 1'b0;
        #1;
        check("resp_strobes", {bus_if.read, bus_if.write}, 2'b00);
        check("resp_if_done", if_done, !is_d);
        check("resp_d_done",  d_done,  is_d);
        if (!is_d)     check("resp_if_rdata", if_rdata, rd);
        else if (!we)  check("resp_d_rdata",  d_rdata,  rd);
        check("resp_bus_error", bus_error, 1'b0);
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        check("post_busy",  busy, 1'b0);
        check("post_dones", {if_done, d_done}, 2'b00);
    endtask

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_byteenable = 4'd0; d_wdata = 32'd0;
        bus_if.readdata = 32'd0;
        bus_if.waitrequest = 1'b0;

        // Reset state
        tick(); tick(); tick();
        check("rst_read",      bus_if.read,       1'b0);
        check("rst_write",     bus_if.write,      1'b0);
        check("rst_addr",      bus_if.address,    32'd0);
        check("rst_be",        bus_if.byteenable, 4'd0);
        check("rst_wdata",     bus_if.writedata,  32'd0);
        check("rst_dones",     {if_done, d_done}, 2'b00);
        check("rst_busy",      busy,              1'b0);
        check("rst_bus_error", bus_error,         1'b0);
        reset = 1'b0;
        tick();

        // Single fetch, no stalls
        xfer(1'b0, 1'b0, 32'hBFC0_0000, 4'b0000, 32'd0, 0, 32'h2402_0005);

        // Simultaneous fetch and load: load first, fetch after
        if_req = 1'b1; if_addr = 32'hBFC0_0004;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_1000; d_byteenable = 4'b1111; d_wdata = 32'd0;
        bus_if.waitrequest = 1'b0;
        tick();                                                    // cycle 1
        check("arb_c1_read", bus_if.read,    1'b1);
        check("arb_c1_addr", bus_if.address, 32'h0000_1000);
        tick();                                                    // cycle 2
        bus_if.readdata = 32'h1111_2222; #1;
        check("arb_c2_d_done",  d_done,  1'b1);
        check("arb_c2_if_done", if_done, 1'b0);
        check("arb_c2_d_rdata", d_rdata, 32'h1111_2222);
        d_req = 1'b0;
        tick();                                                    // cycle 3
        check("arb_c3_read", bus_if.read, 1'b0);
        tick();                                                    // cycle 4
        check("arb_c4_read", bus_if.read,       1'b1);
        check("arb_c4_addr", bus_if.address,    32'hBFC0_0004);
        check("arb_c4_be",   bus_if.byteenable, 4'b1111);
        tick();                                                    // cycle 5
        bus_if.readdata = 32'h0800_0010; #1;
        check("arb_c5_if_done",  if_done,  1'b1);
        check("arb_c5_if_rdata", if_rdata, 32'h0800_0010);
        if_req = 1'b0;
        tick();
        check("arb_c6_busy", busy, 1'b0);

        // Store with three stall cycles
        xfer(1'b1, 1'b1, 32'h0000_2004, 4'b0011, 32'hDEAD_BEEF, 3, 32'd0);

        // Reset during a stalled read
        if_req = 1'b1; if_addr = 32'h0000_0500; bus_if.waitrequest = 1'b1;
        tick();
        check("rst_mid_read", bus_if.read, 1'b1);
        tick();
        reset = 1'b1; if_req = 1'b0;
        tick();
        check("rst_mid_read_drop", bus_if.read, 1'b0);
        check("rst_mid_busy",      busy,        1'b0);
        check("rst_mid_done",      if_done,     1'b0);
        reset = 1'b0; bus_if.waitrequest = 1'b0;
        tick();
        check("rst_mid_done2", if_done, 1'b0);
        xfer(1'b0, 1'b0, 32'h0000_0504, 4'b0000, 32'd0, 1, 32'hCAFE_F00D);

        // Back-to-back fetches, request kept high across done
        if_req = 1'b1; if_addr = 32'h0000_0000; bus_if.waitrequest = 1'b0;
        tick();                                                    // cycle 1
        check("b2b_read0", bus_if.read,    1'b1);
        check("b2b_addr0", bus_if.address, 32'h0000_0000);
        tick();                                                    // cycle 2
        bus_if.readdata = 32'hAAAA_0001; #1;
        check("b2b_done0",  if_done,  1'b1);
        check("b2b_rdata0", if_rdata, 32'hAAAA_0001);
        if_addr = 32'h0000_0004;
        tick();                                                    // cycle 3
        check("b2b_gap", bus_if.read, 1'b0);
        tick();                                                    // cycle 4
        check("b2b_read1", bus_if.read,    1'b1);
        check("b2b_addr1", bus_if.address, 32'h0000_0004);
        tick();                                                    // cycle 5
        bus_if.readdata = 32'hAAAA_0002; #1;
        check("b2b_done1",  if_done,  1'b1);
        check("b2b_rdata1", if_rdata, 32'hAAAA_0002);
        if_req = 1'b0;
        tick();

        // Randomized transfers
        for (int n = 0; n < 24; n++) begin
            bit         r_is_d;
            bit         r_we;
            logic [3:0] r_be;
            r_is_d = 1'($urandom);
            r_we   = 1'($urandom);
            r_be   = 4'($urandom);
            if (r_be == 4'd0) r_be = 4'b1111;
            xfer(r_is_d, r_we, $urandom & 32'hFFFF_FFFC, r_be, $urandom,
                 $urandom_range(0, 3), $urandom);
        end

`ifdef MIPS_BUS_TIMEOUT_EN
        // Load stuck in waitrequest: abort after 4 stalled cycles
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000; d_byteenable = 4'b1111;
        bus_if.waitrequest = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("to_read_held", bus_if.read, 1'b1);
            check("to_no_done",   d_done,      1'b0);
        end
        tick();
        bus_if.readdata = 32'h1234_5678; #1;
        check("to_read_drop", bus_if.read, 1'b0);
        check("to_d_done",    d_done,      1'b1);
        check("to_d_rdata",   d_rdata,     32'd0);
        check("to_bus_error", bus_error,   1'b1);
        d_req = 1'b0; bus_if.waitrequest = 1'b0;
        tick(); tick();
        check("to_sticky", bus_error, 1'b1);
        check("to_idle",   busy,      1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("to_cleared", bus_error, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
